div_issue_ctrl: RTL and testbench

// Sequences the two multi-cycle AXI-stream divider IPs (signed, unsigned) used by EXE for div.w/mod.w/div.wu/mod.wu.

---
 rtl/div_issue_ctrl.sv | 177 +++++++++++++++++
 tb/tb_div_issue_ctrl.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_issue_ctrl.sv
// Issue/handshake controller for the signed and unsigned AXI-stream divider IPs.
// Latches operands, drives tvalid, collects quotient/remainder and stalls EXE until done.
module div_issue_ctrl #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              op_valid,
  input  logic              op_signed,
  input  logic              op_mod,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  input  logic              flush,
  input  logic              res_ack,

  output logic              div_busy,
  output logic              res_valid,
  output logic [XLEN-1:0]   res_data,

  output logic [XLEN-1:0]   dividend_tdata,
  output logic [XLEN-1:0]   divisor_tdata,

  output logic              s_dividend_tvalid,
  input  logic              s_dividend_tready,
  output logic              s_divisor_tvalid,
  input  logic              s_divisor_tready,

  output logic              u_dividend_tvalid,
  input  logic              u_dividend_tready,
  output logic              u_divisor_tvalid,
  input  logic              u_divisor_tready,

  input  logic              s_dout_tvalid,
  input  logic [2*XLEN-1:0] s_dout_tdata,
  input  logic              u_dout_tvalid,
  input  logic [2*XLEN-1:0] u_dout_tdata,

  output logic [CNT_W-1:0]  div_cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  logic              op_signed_q;
  logic              op_mod_q;
  logic              cancel;
  logic              dvd_sent;
  logic              dvs_sent;

  logic              dvd_hs;
  logic              dvs_hs;
  logic              dvd_done;
  logic              dvs_done;
  logic              dout_valid_sel;
  logic [2*XLEN-1:0] dout_data_sel;
  logic [XLEN-1:0]   result_sel;
  logic              discard;
  logic              in_flight;

  // Handshake on the IP chosen for the latched op; the other IP never sees tvalid.
  assign dvd_hs = op_signed_q ? (s_dividend_tvalid & s_dividend_tready)
                              : (u_dividend_tvalid & u_dividend_tready);
  assign dvs_hs = op_signed_q ? (s_divisor_tvalid & s_divisor_tready)
                              : (u_divisor_tvalid & u_divisor_tready);

  assign dvd_done = dvd_sent | dvd_hs;
  assign dvs_done = dvs_sent | dvs_hs;

  // Result path only listens to the selected IP.
  assign dout_valid_sel = op_signed_q ? s_dout_tvalid : u_dout_tvalid;
  assign dout_data_sel  = op_signed_q ? s_dout_tdata  : u_dout_tdata;
  assign result_sel     = op_mod_q ? dout_data_sel[XLEN-1:0]
                                   : dout_data_sel[2*XLEN-1:XLEN];

  // A flush arriving together with the result still kills it.
  assign discard   = cancel | flush;
  assign in_flight = (state == SEND) || (state == WAIT);

  assign div_busy = (op_valid & (state != DONE)) | (cancel & (state != IDLE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      op_signed_q       <= 1'b0;
      op_mod_q          <= 1'b0;
      cancel            <= 1'b0;
      dvd_sent          <= 1'b0;
      dvs_sent          <= 1'b0;
      res_valid         <= 1'b0;
      res_data          <= '0;
      dividend_tdata    <= '0;
      divisor_tdata     <= '0;
      s_dividend_tvalid <= 1'b0;
      s_divisor_tvalid  <= 1'b0;
      u_dividend_tvalid <= 1'b0;
      u_divisor_tvalid  <= 1'b0;
      div_cycles        <= '0;
    end else begin
      if (in_flight) begin
        div_cycles <= div_cycles + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          cancel <= 1'b0;
          if (op_valid && !flush) begin
            op_signed_q       <= op_signed;
            op_mod_q          <= op_mod;
            dividend_tdata    <= src1;
            divisor_tdata     <= src2;
            dvd_sent          <= 1'b0;
            dvs_sent          <= 1'b0;
            s_dividend_tvalid <= op_signed;
            s_divisor_tvalid  <= op_signed;
            u_dividend_tvalid <= ~op_signed;
            u_divisor_tvalid  <= ~op_signed;
            state             <= SEND;
          end
        end

        SEND: begin
          // Flushed ops keep handshaking so the IP is drained cleanly.
          if (flush) begin
            cancel <= 1'b1;
          end
          if (dvd_hs) begin
            dvd_sent          <= 1'b1;
            s_dividend_tvalid <= 1'b0;
            u_dividend_tvalid <= 1'b0;
          end
          if (dvs_hs) begin
            dvs_sent         <= 1'b1;
            s_divisor_tvalid <= 1'b0;
            u_divisor_tvalid <= 1'b0;
          end
          if (dvd_done && dvs_done) begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (dout_valid_sel) begin
            if (discard) begin
              cancel <= 1'b0;
              state  <= IDLE;
            end else begin
              res_data  <= result_sel;
              res_valid <= 1'b1;
              state     <= DONE;
            end
          end else if (flush) begin
            cancel <= 1'b1;
          end
        end

        DONE: begin
          if (res_ack || flush) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: table vectors, randomized ops against an
// arithmetic divider model, and hand-written flush/reset/ack sequences.
module tb_div_issue_ctrl;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;

  logic              clk;
  logic              reset;
  logic              op_valid;
  logic              op_signed;
  logic              op_mod;
  logic [XLEN-1:0]   src1;
  logic [XLEN-1:0]   src2;
  logic              flush;
  logic              res_ack;
  logic              div_busy;
  logic              res_valid;
  logic [XLEN-1:0]   res_data;
  logic [XLEN-1:0]   dividend_tdata;
  logic [XLEN-1:0]   divisor_tdata;
  logic              s_dividend_tvalid;
  logic              s_dividend_tready;
  logic              s_divisor_tvalid;
  logic              s_divisor_tready;
  logic              u_dividend_tvalid;
  logic              u_dividend_tready;
  logic              u_divisor_tvalid;
  logic              u_divisor_tready;
  logic              s_dout_tvalid;
  logic [2*XLEN-1:0] s_dout_tdata;
  logic              u_dout_tvalid;
  logic [2*XLEN-1:0] u_dout_tdata;
  logic [CNT_W-1:0]  div_cycles;
  logic              any_tvalid;

  int n_chk;
  int n_fail;

  div_issue_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .op_valid          (op_valid),
    .op_signed         (op_signed),
    .op_mod            (op_mod),
    .src1              (src1),
    .src2              (src2),
    .flush             (flush),
    .res_ack           (res_ack),
    .div_busy          (div_busy),
    .res_valid         (res_valid),
    .res_data          (res_data),
    .dividend_tdata    (dividend_tdata),
    .divisor_tdata     (divisor_tdata),
    .s_dividend_tvalid (s_dividend_tvalid),
    .s_dividend_tready (s_dividend_tready),
    .s_divisor_tvalid  (s_divisor_tvalid),
    .s_divisor_tready  (s_divisor_tready),
    .u_dividend_tvalid (u_dividend_tvalid),
    .u_dividend_tready (u_dividend_tready),
    .u_divisor_tvalid  (u_divisor_tvalid),
    .u_divisor_tready  (u_divisor_tready),
    .s_dout_tvalid     (s_dout_tvalid),
    .s_dout_tdata      (s_dout_tdata),
    .u_dout_tvalid     (u_dout_tvalid),
    .u_dout_tdata      (u_dout_tdata),
    .div_cycles        (div_cycles)
  );

  assign any_tvalid = s_dividend_tvalid | s_divisor_tvalid | u_dividend_tvalid | u_divisor_tvalid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  typedef struct {
    logic        sgn;
    logic        md;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          dd;
    int          vd;
    int          lat;
    int          ack_d;
  } vec_t;

  vec_t vecs [0:11];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0b required=%0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural divider: truncating division, x/0 gives all-ones quotient and remainder x.
  function automatic logic [63:0] ip_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0]        q;
    logic [31:0]        r;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (sgn) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_ips();
    s_dividend_tready = 1'b0;
    s_divisor_tready  = 1'b0;
    u_dividend_tready = 1'b0;
    u_divisor_tready  = 1'b0;
    s_dout_tvalid     = 1'b0;
    u_dout_tvalid     = 1'b0;
    s_dout_tdata      = '0;
    u_dout_tdata      = '0;
  endtask

  // Selected IP gets the scripted behaviour; the other IP produces random noise.
  task automatic drive_ips(input logic sgn, input logic dvd_rdy, input logic dvs_rdy,
                           input logic dout_v, input logic [63:0] dout);
    if (sgn) begin
      s_dividend_tready = dvd_rdy;
      s_divisor_tready  = dvs_rdy;
      s_dout_tvalid     = dout_v;
      s_dout_tdata      = dout_v ? dout : {$urandom, $urandom};
      u_dividend_tready = 1'($urandom);
      u_divisor_tready  = 1'($urandom);
      u_dout_tvalid     = 1'($urandom);
      u_dout_tdata      = {$urandom, $urandom};
    end else begin
      u_dividend_tready = dvd_rdy;
      u_divisor_tready  = dvs_rdy;
      u_dout_tvalid     = dout_v;
      u_dout_tdata      = dout_v ? dout : {$urandom, $urandom};
      s_dividend_tready = 1'($urandom);
      s_divisor_tready  = 1'($urandom);
      s_dout_tvalid     = 1'($urandom);
      s_dout_tdata      = {$urandom, $urandom};
    end
  endtask

  // One full op from an IDLE cycle (cycle 0) through retirement; returns in the IDLE cycle after.
  task automatic run_op(input logic sgn, input logic md, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int dd, input int vd, input int lat,
                        input int ack_d, input bit use_flush);
    logic [63:0] dout;
    logic [31:0] c0;
    logic        dvd_rdy;
    logic        dvs_rdy;
    logic        sel_dvd_v;
    logic        sel_dvs_v;
    logic        oth_v;
    int          hs_dvd;
    int          hs_dvs;
    int          n;
    int          k;
    dout = ip_model(sgn, a, b);
    op_valid  = 1'b1;
    op_signed = sgn;
    op_mod    = md;
    src1      = a;
    src2      = b;
    flush     = 1'b0;
    res_ack   = 1'b0;
    quiet_ips();
    #1;
    chk1("busy_on_accept", div_busy, 1'b1);
    chk1("idle_no_tvalid", any_tvalid, 1'b0);
    c0 = div_cycles;
    hs_dvd = 0;
    hs_dvs = 0;
    n = -1;
    k = 1;
    step();
    while (k < 200) begin
      dvd_rdy = (k >= 1 + dd);
      dvs_rdy = (k >= 1 + vd);
      drive_ips(sgn, dvd_rdy, dvs_rdy, (k == n), dout);
      #1;
      if (res_valid) break;
      sel_dvd_v = sgn ? s_dividend_tvalid : u_dividend_tvalid;
      sel_dvs_v = sgn ? s_divisor_tvalid  : u_divisor_tvalid;
      oth_v     = sgn ? (u_dividend_tvalid | u_divisor_tvalid) : (s_dividend_tvalid | s_divisor_tvalid);
      chk1("other_ip_tvalid", oth_v, 1'b0);
      chk1("dividend_tvalid", sel_dvd_v, (hs_dvd == 0));
      chk1("divisor_tvalid", sel_dvs_v, (hs_dvs == 0));
      chk1("busy_in_flight", div_busy, 1'b1);
      if (sel_dvd_v) chk32("dividend_tdata", dividend_tdata, a);
      if (sel_dvs_v) chk32("divisor_tdata", divisor_tdata, b);
      if (sel_dvd_v && dvd_rdy) hs_dvd++;
      if (sel_dvs_v && dvs_rdy) hs_dvs++;
      if (n < 0 && hs_dvd > 0 && hs_dvs > 0) n = k + lat;
      step();
      k++;
    end
    chk32("res_latency", 32'(k), 32'(n + 1));
    chk32("res_data", res_data, exp);
    chk32("dividend_handshakes", 32'(hs_dvd), 32'd1);
    chk32("divisor_handshakes", 32'(hs_dvs), 32'd1);
    chk32("div_cycles_delta", div_cycles - c0, 32'(n));
    for (int j = 0; j < ack_d; j++) begin
      chk1("hold_res_valid", res_valid, 1'b1);
      chk32("hold_res_data", res_data, exp);
      chk1("hold_busy_low", div_busy, 1'b0);
      step();
      drive_ips(sgn, 1'b0, 1'b0, 1'b0, 64'd0);
      #1;
    end
    chk1("done_res_valid", res_valid, 1'b1);
    if (use_flush) flush = 1'b1;
    else res_ack = 1'b1;
    step();
    flush    = 1'b0;
    res_ack  = 1'b0;
    op_valid = 1'b0;
    quiet_ips();
    #1;
    chk1("retired_res_valid", res_valid, 1'b0);
    chk1("retired_busy", div_busy, 1'b0);
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    reset     = 1'b1;
    op_valid  = 1'b0;
    op_signed = 1'b0;
    op_mod    = 1'b0;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    res_ack   = 1'b0;
    quiet_ips();

    vecs[0]  = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 0, 9, 0};
    vecs[1]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'd10,        32'd5,         0, 0, 3, 1};
    vecs[2]  = '{1'b0, 1'b0, 32'd100,       32'd7,         32'd14,        0, 3, 2, 0};
    vecs[3]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 2, 1, 1, 3};
    vecs[4]  = '{1'b0, 1'b0, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1, 2, 0};
    vecs[5]  = '{1'b0, 1'b1, 32'd5,         32'd0,         32'd5,         0, 2, 1, 1};
    vecs[6]  = '{1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 4, 0};
    vecs[7]  = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         3, 0, 1, 0};
    vecs[8]  = '{1'b1, 1'b0, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1, 0, 5, 2};
    vecs[9]  = '{1'b1, 1'b1, 32'd100,       32'hFFFF_FFF9, 32'd2,         0, 0, 1, 0};
    vecs[10] = '{1'b1, 1'b0, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 0, 0, 2, 0};
    vecs[11] = '{1'b0, 1'b0, 32'hFFFF_FFF0, 32'd1,         32'hFFFF_FFF0, 4, 4, 6, 0};

    #2;
    chk1("reset_res_valid", res_valid, 1'b0);
    chk32("reset_res_data", res_data, 32'd0);
    chk1("reset_tvalid", any_tvalid, 1'b0);
    chk32("reset_div_cycles", div_cycles, 32'd0);
    chk32("reset_dividend_tdata", dividend_tdata, 32'd0);
    step();
    reset = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].sgn, vecs[i].md, vecs[i].a, vecs[i].b, vecs[i].exp,
             vecs[i].dd, vecs[i].vd, vecs[i].lat, vecs[i].ack_d, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      logic        sgn;
      logic        md;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] qr;
      sgn = 1'($urandom);
      md  = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom;
        2:       b = 32'(-int'($urandom_range(1, 50)));
        default: b = $urandom_range(1, 100);
      endcase
      qr = ip_model(sgn, a, b);
      run_op(sgn, md, a, b, md ? qr[31:0] : qr[63:32],
             int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
             int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 1'b0);
    end

    // Flush in WAIT, new op presented right after: old result drained and dropped first.
    op_valid  = 1'b1;
    op_signed = 1'b1;
    op_mod    = 1'b0;
    src1      = 32'd20;
    src2      = 32'd3;
    step();
    s_dividend_tready = 1'b1;
    s_divisor_tready  = 1'b1;
    #1;
    chk1("flw_dividend_tvalid", s_dividend_tvalid, 1'b1);
    step();
    s_dividend_tready = 1'b0;
    s_divisor_tready  = 1'b0;
    step();
    flush = 1'b1;
    #1;
    chk1("flw_busy_at_flush", div_busy, 1'b1);
    step();
    flush = 1'b0;
    src1  = 32'd50;
    src2  = 32'd5;
    for (int c = 4; c <= 6; c++) begin
      if (c == 6) begin
        s_dout_tvalid = 1'b1;
        s_dout_tdata  = ip_model(1'b1, 32'd20, 32'd3);
      end
      #1;
      chk1("flw_busy_drain", div_busy, 1'b1);
      chk1("flw_no_issue", any_tvalid, 1'b0);
      chk1("flw_no_res", res_valid, 1'b0);
      chk32("flw_latched_dividend", dividend_tdata, 32'd20);
      step();
    end
    s_dout_tvalid = 1'b0;
    #1;
    chk1("flw_idle_no_res", res_valid, 1'b0);
    chk1("flw_idle_no_issue", any_tvalid, 1'b0);
    run_op(1'b1, 1'b0, 32'd50, 32'd5, 32'd10, 0, 0, 3, 0, 1'b0);

    // Back-to-back op straight after a delayed ack, then one retired by flush in DONE.
    run_op(1'b0, 1'b1, 32'd17, 32'd5, 32'd2, 0, 0, 2, 3, 1'b0);
    run_op(1'b1, 1'b0, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C, 1, 0, 2, 1, 1'b1);

    // Flush together with op_valid in IDLE: nothing issued.
    op_valid  = 1'b1;
    op_signed = 1'b0;
    flush     = 1'b1;
    step();
    op_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk1("idle_flush_no_issue", any_tvalid, 1'b0);
    chk1("idle_flush_busy", div_busy, 1'b0);
    step();
    chk1("idle_flush_no_issue2", any_tvalid, 1'b0);

    // Flush in SEND: tvalid held until handshakes complete, busy stays high until drained.
    op_valid  = 1'b1;
    op_signed = 1'b0;
    op_mod    = 1'b1;
    src1      = 32'd17;
    src2      = 32'd5;
    step();
    flush = 1'b1;
    #1;
    chk1("fls_tvalid_c1", u_dividend_tvalid, 1'b1);
    step();
    flush    = 1'b0;
    op_valid = 1'b0;
    #1;
    chk1("fls_dividend_kept", u_dividend_tvalid, 1'b1);
    chk1("fls_divisor_kept", u_divisor_tvalid, 1'b1);
    chk1("fls_busy_cancel", div_busy, 1'b1);
    step();
    u_dividend_tready = 1'b1;
    u_divisor_tready  = 1'b1;
    step();
    u_dividend_tready = 1'b0;
    u_divisor_tready  = 1'b0;
    #1;
    chk1("fls_wait_no_tvalid", any_tvalid, 1'b0);
    chk1("fls_wait_busy", div_busy, 1'b1);
    step();
    u_dout_tvalid = 1'b1;
    u_dout_tdata  = ip_model(1'b0, 32'd17, 32'd5);
    step();
    u_dout_tvalid = 1'b0;
    #1;
    chk1("fls_no_res", res_valid, 1'b0);
    chk1("fls_busy_released", div_busy, 1'b0);

    // Reset between edges while waiting for the IP.
    op_valid  = 1'b1;
    op_signed = 1'b1;
    op_mod    = 1'b0;
    src1      = 32'd9;
    src2      = 32'd4;
    step();
    s_dividend_tready = 1'b1;
    s_divisor_tready  = 1'b1;
    step();
    s_dividend_tready = 1'b0;
    s_divisor_tready  = 1'b0;
    #1;
    chk1("rst_pre_cycles_nonzero", (div_cycles != '0), 1'b1);
    chk1("rst_pre_res_data_nonzero", (res_data != '0), 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("rst_wait_res_valid", res_valid, 1'b0);
    chk1("rst_wait_tvalid", any_tvalid, 1'b0);
    chk32("rst_wait_div_cycles", div_cycles, 32'd0);
    chk32("rst_wait_res_data", res_data, 32'd0);
    op_valid = 1'b0;
    step();
    reset = 1'b0;
    step();

    // Reset between edges while tvalid is asserted.
    op_valid = 1'b1;
    step();
    #1;
    chk1("rst_send_tvalid_pre", s_dividend_tvalid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1("rst_send_tvalid", any_tvalid, 1'b0);
    op_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    run_op(1'b0, 1'b0, 32'd81, 32'd9, 32'd9, 0, 0, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
